// File: rtl/trigger_pkg.sv
// Shared constants for the trigger event path: channel count, event ID width
// and the layout of the packed event record {pattern, id, timestamp}.
package trigger_pkg;

  localparam int unsigned CHANNELS = 16;
  localparam int unsigned ID_W     = 16;
  localparam int unsigned PAT_W    = CHANNELS;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_DEAD = 1'b1
  } trig_state_t;

  // Record layout: timestamp in the low bits, then id, then pattern on top.
  // A zero timestamp width gives the timestamp-less record {pattern, id}.
  function automatic int unsigned ts_ofs(input int unsigned ts_w);
    return 0 * ts_w;
  endfunction

  function automatic int unsigned id_ofs(input int unsigned ts_w);
    return ts_w;
  endfunction

  function automatic int unsigned pat_ofs(input int unsigned ts_w);
    return ts_w + ID_W;
  endfunction

  function automatic int unsigned rec_w(input int unsigned ts_w);
    return ts_w + ID_W + PAT_W;
  endfunction

endpackage

// File: rtl/trigevent_fifo.sv
// Synchronous FIFO with registered occupancy and first-word-fall-through read.
// Pushes while full and pops while empty are ignored.
module trigevent_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are only observed through valid entries, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trigger_event_latch.sv
// Trigger event latch: edge-detects the coincidence result, applies a
// deadtime veto, captures {pattern, id, timestamp} records into a FIFO and
// presents them on a valid/ready port.
// Optional feature macro: TRIGLATCH_TIMESTAMP_EN builds the timestamp counter
// and per-entry timestamp storage; without it evt_timestamp is tied to 0.
module trigger_event_latch
  import trigger_pkg::*;
#(
  parameter int unsigned DEADTIME   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_WIDTH   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] triggers,
  input  logic                triggered,
  output logic                evt_valid,
  input  logic                evt_ready,
  output logic [PAT_W-1:0]    evt_pattern,
  output logic [ID_W-1:0]     evt_id,
  output logic [TS_WIDTH-1:0] evt_timestamp,
  output logic                busy,
  output logic [15:0]         dropped_count
);

`ifdef TRIGLATCH_TIMESTAMP_EN
  localparam int unsigned TS_STORE_W = TS_WIDTH;
  localparam int unsigned TS_OFS     = ts_ofs(TS_STORE_W);
`else
  localparam int unsigned TS_STORE_W = 0;
`endif
  localparam int unsigned REC_W   = rec_w(TS_STORE_W);
  localparam int unsigned ID_OFS  = id_ofs(TS_STORE_W);
  localparam int unsigned PAT_OFS = pat_ofs(TS_STORE_W);
  localparam int unsigned CNT_W   = (DEADTIME > 0) ? $clog2(DEADTIME + 1) : 1;

  trig_state_t      state;
  logic [CNT_W-1:0] dead_cnt;
  logic             trig_q;
  logic             trig_edge;
  logic             accept;
  logic [ID_W-1:0]  id_cnt;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_out;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;

  assign trig_edge = triggered & ~trig_q;
  assign accept    = trig_edge & (state == ST_IDLE);
  assign fifo_push = accept & ~fifo_full;
  assign fifo_pop  = evt_valid & evt_ready;

`ifdef TRIGLATCH_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_cnt;

  // Free-running timestamp, wraps at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_cnt <= '0;
    else        ts_cnt <= ts_cnt + TS_WIDTH'(1);
  end
`endif

  // Assemble the record captured on an accepted edge.
  always_comb begin
    rec_in                   = '0;
    rec_in[PAT_OFS +: PAT_W] = triggers;
    rec_in[ID_OFS +: ID_W]   = id_cnt;
`ifdef TRIGLATCH_TIMESTAMP_EN
    rec_in[TS_OFS +: TS_WIDTH] = ts_cnt;
`endif
  end

  // Deadtime FSM: accepted edge loads the veto counter, release at count 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      dead_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (DEADTIME > 0)) begin
            state    <= ST_DEAD;
            dead_cnt <= CNT_W'(DEADTIME);
          end
        end
        ST_DEAD: begin
          if (dead_cnt == CNT_W'(1)) state <= ST_IDLE;
          else                       dead_cnt <= dead_cnt - CNT_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Edge history, event ID and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q        <= 1'b0;
      id_cnt        <= '0;
      dropped_count <= '0;
    end else begin
      trig_q <= triggered;
      if (accept) begin
        id_cnt <= id_cnt + ID_W'(1);
        if (fifo_full && (dropped_count != 16'hFFFF))
          dropped_count <= dropped_count + 16'd1;
      end
    end
  end

  trigevent_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (rec_in),
    .pop   (fifo_pop),
    .rdata (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head outputs decode registered FIFO state only; zero whenever nothing is queued.
  assign evt_valid   = ~fifo_empty;
  assign evt_pattern = evt_valid ? rec_out[PAT_OFS +: PAT_W] : '0;
  assign evt_id      = evt_valid ? rec_out[ID_OFS +: ID_W]   : '0;
`ifdef TRIGLATCH_TIMESTAMP_EN
  assign evt_timestamp = evt_valid ? rec_out[TS_OFS +: TS_WIDTH] : '0;
`else
  assign evt_timestamp = '0;
`endif
  assign busy = (state == ST_DEAD) | fifo_full;

endmodule
